// File: rtl/emboss_stream_if.sv
// emboss_stream_if
//   Groups the pixel input stream and the embossed output stream of
//   emboss_stream_ctrl.
//
//   Both streams use the same valid/ready rule. A transfer happens on a rising
//   clock edge where valid and ready are both high. Once the sender raises
//   valid, it keeps valid and data stable until that transfer happens. ready
//   may change freely and may depend on valid.
//
//   Signals
//     s_valid, s_pix, s_ready : raster pixel stream into the controller
//     m_valid, m_pix, m_ready : embossed pixel stream out of the controller
//   Modports
//     slave  : controller side (consumes s_*, produces m_*)
//     master : environment side (produces s_*, consumes m_*)
interface emboss_stream_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_pix;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_pix;

    modport slave (
        input  s_valid, s_pix, m_ready,
        output s_ready, m_valid, m_pix
    );

    modport master (
        output s_valid, s_pix, m_ready,
        input  s_ready, m_valid, m_pix
    );
endinterface

// File: rtl/emboss_stream_ctrl.sv
// emboss_stream_ctrl
//   Frame sequencer for an external combinational emboss_core. It takes a
//   raster pixel stream and keeps two line buffers plus a 3x3 window. It shows
//   each window to the core on win and registers the core result onto the
//   output stream. Only interior pixels are emitted, which gives
//   (IMG_W-2)*(IMG_H-2) outputs per frame. done pulses for one cycle after the
//   last output handshake.
//
//   Optional feature macro: EMBOSS_BYPASS_EN. When it is defined, the bypass
//   input exists. With bypass=1 the output takes the window centre instead of
//   core_pix.
//
//   Ports
//     clk       : rising-edge clock
//     rst_n     : asynchronous active-low reset
//     start     : frame start request, only looked at in IDLE
//     st        : stream interface, slave side (s_valid/s_ready/s_pix in,
//                 m_valid/m_ready/m_pix out)
//     win       : {p00,p01,p02,p10,p11,p12,p20,p21,p22}, p00 in [71:64]
//     core_pix  : emboss_core result for the current win
//     busy      : high while a frame is being read in (RUN)
//     done      : one-cycle pulse after the last output handshake
//     bypass    : present only with EMBOSS_BYPASS_EN
//     dbg_state : current FSM state (0 IDLE, 1 RUN, 2 FLUSH, 3 DONE)
module emboss_stream_ctrl #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    emboss_stream_if.slave        st,
    output logic [71:0]           win,
    input  logic [7:0]            core_pix,
    output logic                  busy,
    output logic                  done,
`ifdef EMBOSS_BYPASS_EN
    input  logic                  bypass,
`endif
    output logic [1:0]            dbg_state
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          accept;
    logic          x_last;
    logic          y_last;

    // Line buffers. lb1 holds row y-2 and lb0 holds row y-1.
    // They are not reset.
    logic [7:0] lb0 [IMG_W];
    logic [7:0] lb1 [IMG_W];

    // Registered window columns 0 and 1, each listed top/mid/bottom.
    logic [7:0] c0_t, c0_m, c0_b;
    logic [7:0] c1_t, c1_m, c1_b;
    // Column 2 is taken straight from the buffers and the incoming pixel.
    logic [7:0] c2_t, c2_m, c2_b;

    logic       m_valid_q;
    logic [7:0] m_pix_q;
    logic [7:0] out_sel;

    assign x_last = (x == XW'(IMG_W - 1));
    assign y_last = (y == YW'(IMG_H - 1));

    // Output register slot is free, or it empties on this same edge.
    assign st.s_ready = (state == S_RUN) && (!m_valid_q || st.m_ready);
    assign accept     = st.s_valid && st.s_ready;

    assign c2_t = lb1[x];
    assign c2_m = lb0[x];
    assign c2_b = st.s_pix;

    assign win = {c0_t, c1_t, c2_t, c0_m, c1_m, c2_m, c0_b, c1_b, c2_b};

`ifdef EMBOSS_BYPASS_EN
    assign out_sel = bypass ? c1_m : core_pix;
`else
    assign out_sel = core_pix;
`endif

    assign st.m_valid = m_valid_q;
    assign st.m_pix   = m_pix_q;
    assign busy       = (state == S_RUN);
    assign done       = (state == S_DONE);
    assign dbg_state  = state;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (accept && x_last && y_last) state_nxt = S_FLUSH;
            // Wait until the final output leaves the register.
            S_FLUSH: if (!m_valid_q || st.m_ready) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- raster counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (state == S_IDLE && start) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // ---------------- line buffers ----------------
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[x] <= lb0[x];
            lb0[x] <= st.s_pix;
        end
    end

    // ---------------- window columns ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0_t <= '0; c0_m <= '0; c0_b <= '0;
            c1_t <= '0; c1_m <= '0; c1_b <= '0;
        end else if (accept) begin
            c0_t <= c1_t; c0_m <= c1_m; c0_b <= c1_b;
            c1_t <= c2_t; c1_m <= c2_m; c1_b <= c2_b;
        end
    end

    // ---------------- output register ----------------
    // At x<2 the registered columns still hold the previous row's data.
    // Those windows are skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_pix_q   <= '0;
        end else if (accept && (y >= YW'(2)) && (x >= XW'(2))) begin
            m_valid_q <= 1'b1;
            m_pix_q   <= out_sel;
        end else if (st.m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_emboss_stream_ctrl.sv
module tb_emboss_stream_ctrl;

  localparam int W = 8;
  localparam int H = 6;
  localparam int NOUT = (W - 2) * (H - 2);

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [71:0] win;
  logic [7:0]  core_pix;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;
`ifdef EMBOSS_BYPASS_EN
  logic        bypass;
`endif

  emboss_stream_if sif ();

  emboss_stream_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .st        (sif),
    .win       (win),
    .core_pix  (core_pix),
    .busy      (busy),
    .done      (done),
`ifdef EMBOSS_BYPASS_EN
    .bypass    (bypass),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- emboss kernel (stands in for emboss_core) ----------------
  function automatic logic [7:0] kern(input logic [71:0] w);
    int s;
    s = -2 * int'(w[71:64]) - int'(w[63:56])
        - int'(w[47:40]) + int'(w[39:32]) + int'(w[31:24])
        + int'(w[15:8]) + 2 * int'(w[7:0]) + 128;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s[7:0];
  endfunction

  always_comb core_pix = kern(win);

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] img [H][W];
  logic [7:0] got [NOUT];
  int out_idx = 0;
  int done_cnt = 0;
  int sample_idx = 0;
  int last_hs_idx = -10;
  int rdy_mode = 0;
  int gap_mode = 0;
  int byp_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the frame is kept as a plain image. Each interior centre is
  // computed from its 3x3 neighbourhood as soon as the bottom-right pixel
  // of that neighbourhood has been accepted.
  task automatic model_accept(input int y, input int x, input logic [7:0] p);
    logic [71:0] w;
    img[y][x] = p;
    if (y >= 2 && x >= 2) begin
      if (byp_en != 0) begin
        exp_q.push_back(img[y-1][x-1]);
      end else begin
        w = {img[y-2][x-2], img[y-2][x-1], img[y-2][x],
             img[y-1][x-2], img[y-1][x-1], img[y-1][x],
             img[y][x-2],   img[y][x-1],   img[y][x]};
        exp_q.push_back(kern(w));
      end
    end
  endtask

  // ---------------- m_ready driver ----------------
  initial begin
    sif.m_ready = 1'b1;
    forever begin
      @(negedge clk);
      sif.m_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- compare process ----------------
  initial begin : compare
    logic       stall_pend;
    logic [7:0] stall_pix;
    logic [7:0] e;
    stall_pend = 1'b0;
    stall_pix  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall_pend = 1'b0;
        continue;
      end
      if (stall_pend) begin
        chk("stall_valid", int'(sif.m_valid), 1);
        chk("stall_pix", int'(sif.m_pix), int'(stall_pix));
      end
      stall_pend = 1'b0;
      if (done) begin
        done_cnt++;
        chk("done_gap", sample_idx - last_hs_idx, 1);
      end
      if (sif.m_valid && sif.m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", int'(sif.m_pix), -1);
        end else begin
          e = exp_q.pop_front();
          chk("out_pix", int'(sif.m_pix), int'(e));
          if (out_idx < NOUT) got[out_idx] = sif.m_pix;
          out_idx++;
        end
        last_hs_idx = sample_idx;
      end else if (sif.m_valid) begin
        stall_pend = 1'b1;
        stall_pix  = sif.m_pix;
      end
      sample_idx++;
    end
  end

  // ---------------- stimulus tasks ----------------
  function automatic logic [7:0] pix_of(input int kind, input int x);
    case (kind)
      0: return 8'd50;
      1: return 8'd0;
      2: return 8'd255;
      3: return 8'(x * 10);
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic send_pix(input int y, input int x, input logic [7:0] p);
    int guard;
    if (gap_mode != 0) begin
      while ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        sif.s_valid = 1'b0;
        sif.s_pix   = 8'($urandom_range(0, 255));
      end
    end
    @(negedge clk);
    sif.s_valid = 1'b1;
    sif.s_pix   = p;
    guard = 0;
    forever begin
      #1;
      if (sif.s_ready) break;
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        chk("accept_timeout", 0, 1);
        return;
      end
    end
    model_accept(y, x, p);
    @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_frame();
    int d0;
    int guard;
    @(negedge clk);
    sif.s_valid = 1'b0;
    d0 = done_cnt;
    guard = 0;
    while (done_cnt == d0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("done_seen", int'(done_cnt > d0), 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("out_count", out_idx, NOUT);
    chk("exp_q_empty", exp_q.size(), 0);
    #1;
    chk("idle_busy", int'(busy), 0);
  endtask

  task automatic run_frame(input int kind, input int rmode, input int gmode, input int start_mid);
    rdy_mode = rmode;
    gap_mode = gmode;
    out_idx  = 0;
    pulse_start();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (start_mid != 0 && y == 2 && x == 3) start = 1'b1;
        send_pix(y, x, pix_of(kind, x));
        if (start_mid != 0 && y == 2 && x == 3) begin
          start = 1'b0;
          #1;
          chk("busy_mid", int'(busy), 1);
        end
      end
    end
    finish_frame();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_pix   = '0;
`ifdef EMBOSS_BYPASS_EN
    bypass = 1'b0;
`endif
    #12;
    chk("rst_m_valid", int'(sif.m_valid), 0);
    chk("rst_m_pix", int'(sif.m_pix), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_s_ready", int'(sif.s_ready), 0);
    chk("rst_state", int'(dbg_state), 0);
    chk("rst_win_lo", int'(win[47:0] & 48'hFF_FF00_FF00), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Flat 50, always ready
    run_frame(0, 0, 0, 0);
    chk("flat50_first", int'(got[0]), 178);
    chk("flat50_last", int'(got[NOUT-1]), 178);

    // Flat 0 and flat 255 (clip)
    run_frame(1, 0, 0, 0);
    chk("flat0_first", int'(got[0]), 128);
    run_frame(2, 0, 0, 0);
    chk("flat255_last", int'(got[NOUT-1]), 255);

    // Ramp x*10: centre c gives c+60+128
    run_frame(3, 0, 0, 0);
    chk("ramp_first", int'(got[0]), 198);
    chk("ramp_row_end", int'(got[5]), 248);
    chk("ramp_row2", int'(got[6]), 198);

    // Random image, random ready and input gaps
    run_frame(4, 1, 1, 0);
    run_frame(4, 1, 1, 0);

    // start pulsed mid-frame is ignored
    run_frame(4, 1, 0, 1);

    // s_valid in IDLE is not accepted
    @(negedge clk);
    sif.s_valid = 1'b1;
    sif.s_pix   = 8'd77;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_s_ready", int'(sif.s_ready), 0);
      @(negedge clk);
    end
    #1;
    chk("idle_no_out", int'(sif.m_valid), 0);
    sif.s_valid = 1'b0;

    // Reset after 20 input pixels
    rdy_mode = 0;
    gap_mode = 0;
    out_idx  = 0;
    pulse_start();
    for (int i = 0; i < 20; i++) send_pix(i / W, i % W, pix_of(4, i % W));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", int'(sif.m_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_s_ready", int'(sif.s_ready), 0);
    sif.s_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(4, 1, 1, 0);

`ifdef EMBOSS_BYPASS_EN
    bypass = 1'b1;
    byp_en = 1;
    run_frame(3, 0, 0, 0);
    chk("byp_first", int'(got[0]), 10);
    chk("byp_row_end", int'(got[5]), 60);
    bypass = 1'b0;
    byp_en = 0;
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
